// File: rtl/btn_debounce_if.sv
// Button conditioner signal bundle: raw pad in, conditioned level/strobes out.
// The master drives the pad; the slave (the debouncer) drives the conditioned outputs.
interface btn_debounce_if;
  logic i_btn;
  logic o_level;
  logic o_press;
  logic o_release;
  logic o_toggle;

  modport master (
    output i_btn,
    input  o_level,
    input  o_press,
    input  o_release,
    input  o_toggle
  );

  modport slave (
    input  i_btn,
    output o_level,
    output o_press,
    output o_release,
    output o_toggle
  );
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, 4-state debounce FSM,
// registered level, one-cycle press/release strobes and a press-toggled level.
module btn_debounce #(
  parameter int DB_CYCLES     = 1_000_000,
  parameter bit IN_ACTIVE_LOW = 1'b1,
  parameter bit TOGGLE_INIT   = 1'b0
) (
  input  logic          i_clk_fpga,
  input  logic          reset,
  btn_debounce_if.slave btn
);

  localparam int              CNT_W    = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_REL,
    ST_ARM_P,
    ST_PRS,
    ST_ARM_R
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               s1_q, s2_q;
  logic               level_q, level_d;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               toggle_q, toggle_d;
  logic               pressed;

  // NOTE: non-blocking assignments let s2_q capture the old s1_q, forming a real two-stage chain.
  always_ff @(posedge i_clk_fpga) begin
    if (!reset) begin
      s1_q <= IN_ACTIVE_LOW;
      s2_q <= IN_ACTIVE_LOW;
    end else begin
      s1_q <= btn.i_btn;
      s2_q <= s1_q;
    end
  end

  assign pressed = s2_q ^ IN_ACTIVE_LOW;

  always_ff @(posedge i_clk_fpga) begin
    if (!reset) begin
      state_q   <= ST_REL;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= TOGGLE_INIT;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    toggle_d  = toggle_q;

    unique case (state_q)
      ST_REL: begin
        if (pressed) begin
          state_d = ST_ARM_P;
          cnt_d   = '0;
        end
      end
      ST_ARM_P: begin
        if (!pressed) begin
          state_d = ST_REL;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_PRS;
          cnt_d    = '0;
          press_d  = 1'b1;
          toggle_d = ~toggle_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRS: begin
        if (!pressed) begin
          state_d = ST_ARM_R;
          cnt_d   = '0;
        end
      end
      ST_ARM_R: begin
        if (pressed) begin
          state_d = ST_PRS;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_REL;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_REL;
        cnt_d   = '0;
      end
    endcase

    // Level follows the accepted side of the FSM, so it flips on the same edge as the strobe.
    level_d = (state_d == ST_PRS) || (state_d == ST_ARM_R);
  end

  assign btn.o_level   = level_q;
  assign btn.o_press   = press_q;
  assign btn.o_release = release_q;
  assign btn.o_toggle  = toggle_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed vector table, hand-written
// corner sequences and random bounce trains against a run-length reference model.
module tb_btn_debounce;

  localparam int DB = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  btn_debounce_if bif ();

  btn_debounce #(
    .DB_CYCLES    (DB),
    .IN_ACTIVE_LOW(1'b1),
    .TOGGLE_INIT  (1'b0)
  ) dut (
    .i_clk_fpga(clk),
    .reset     (rst_n),
    .btn       (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw samples pass through a two-deep delay queue, then a change
  // is accepted once the delayed "pressed" value has disagreed with the accepted
  // level for DB+1 consecutive edges.
  logic dly[$];
  bit   m_valid;
  logic m_level, m_press, m_rel, m_tog;
  int   m_run;

  task automatic model_edge();
    logic p;
    if (!rst_n) begin
      dly     = {1'b1, 1'b1};
      m_level = 1'b0;
      m_press = 1'b0;
      m_rel   = 1'b0;
      m_tog   = 1'b0;
      m_run   = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      p       = ~dly[0];
      m_press = 1'b0;
      m_rel   = 1'b0;
      if (p != m_level) m_run = m_run + 1;
      else              m_run = 0;
      if (m_run == DB + 1) begin
        m_level = p;
        m_run   = 0;
        if (p) begin
          m_press = 1'b1;
          m_tog   = ~m_tog;
        end else begin
          m_rel = 1'b1;
        end
      end
      void'(dly.pop_front());
      dly.push_back(bif.i_btn);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: advance the model with the inputs about to be sampled, then compare.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (m_valid) begin
      check("model_level",   {31'd0, bif.o_level},   {31'd0, m_level});
      check("model_press",   {31'd0, bif.o_press},   {31'd0, m_press});
      check("model_release", {31'd0, bif.o_release}, {31'd0, m_rel});
      check("model_toggle",  {31'd0, bif.o_toggle},  {31'd0, m_tog});
    end
    check("no_coincide", {31'd0, bif.o_press & bif.o_release}, 32'd0);
  endtask

  typedef struct {
    string name;
    logic  rst_n;
    logic  btn;
    int    cycles;
    logic  level;
    logic  press;
    logic  rel;
    logic  tog;
  } vec_t;

  vec_t vecs[$];
  int   n_press, n_rel;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    m_valid    = 1'b0;
    rst_n      = 1'b0;
    bif.i_btn  = 1'b1;

    // Applied in order; outputs compared after the last edge of each record.
    vecs = '{
      '{"reset_hold",      1'b0, 1'b1, 4,  1'b0, 1'b0, 1'b0, 1'b0},
      '{"post_reset_idle", 1'b1, 1'b1, 3,  1'b0, 1'b0, 1'b0, 1'b0},
      '{"press_qualify",   1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0},
      '{"press_strobe",    1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b1},
      '{"press_one_shot",  1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1'b1},
      '{"press_hold",      1'b1, 1'b0, 5,  1'b1, 1'b0, 1'b0, 1'b1},
      '{"rel_qualify",     1'b1, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b1},
      '{"rel_strobe",      1'b1, 1'b1, 1,  1'b0, 1'b0, 1'b1, 1'b1},
      '{"rel_one_shot",    1'b1, 1'b1, 1,  1'b0, 1'b0, 1'b0, 1'b1},
      '{"press2_strobe",   1'b1, 1'b0, 11, 1'b1, 1'b1, 1'b0, 1'b0},
      '{"press2_after",    1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1'b0},
      '{"rel2_settled",    1'b1, 1'b1, 12, 1'b0, 1'b0, 1'b0, 1'b0}
    };

    foreach (vecs[v]) begin
      rst_n     = vecs[v].rst_n;
      bif.i_btn = vecs[v].btn;
      for (int c = 0; c < vecs[v].cycles; c++) step();
      check({vecs[v].name, "_level"},   {31'd0, bif.o_level},   {31'd0, vecs[v].level});
      check({vecs[v].name, "_press"},   {31'd0, bif.o_press},   {31'd0, vecs[v].press});
      check({vecs[v].name, "_release"}, {31'd0, bif.o_release}, {31'd0, vecs[v].rel});
      check({vecs[v].name, "_toggle"},  {31'd0, bif.o_toggle},  {31'd0, vecs[v].tog});
    end

    // Bounce train: 5 low / 3 high, four times, never long enough to qualify.
    n_press = 0;
    for (int k = 0; k < 4; k++) begin
      bif.i_btn = 1'b0;
      for (int c = 0; c < 5; c++) begin step(); n_press += int'(bif.o_press); end
      bif.i_btn = 1'b1;
      for (int c = 0; c < 3; c++) begin step(); n_press += int'(bif.o_press); end
    end
    for (int c = 0; c < 12; c++) begin step(); n_press += int'(bif.o_press); end
    check("bounce_no_press", n_press, 0);
    check("bounce_level", {31'd0, bif.o_level}, 32'd0);

    // Long hold: exactly one press, then exactly one release.
    n_press   = 0;
    n_rel     = 0;
    bif.i_btn = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      n_press += int'(bif.o_press);
      n_rel   += int'(bif.o_release);
    end
    check("hold_one_press", n_press, 1);
    check("hold_no_release", n_rel, 0);
    check("hold_toggle", {31'd0, bif.o_toggle}, 32'd1);
    bif.i_btn = 1'b1;
    for (int c = 0; c < 12; c++) begin step(); n_rel += int'(bif.o_release); end
    check("hold_one_release", n_rel, 1);

    // Reset in the middle of press qualification (counter at 5), pad kept pressed.
    bif.i_btn = 1'b0;
    for (int c = 0; c < 8; c++) step();
    check("midarm_level", {31'd0, bif.o_level}, 32'd0);
    rst_n = 1'b0;
    step();
    check("midarm_rst_level",  {31'd0, bif.o_level},   32'd0);
    check("midarm_rst_press",  {31'd0, bif.o_press},   32'd0);
    check("midarm_rst_toggle", {31'd0, bif.o_toggle},  32'd0);
    rst_n   = 1'b1;
    n_press = 0;
    for (int c = 0; c < 10; c++) begin step(); n_press += int'(bif.o_press); end
    check("midarm_no_early_press", n_press, 0);
    step();
    check("midarm_fresh_press", {31'd0, bif.o_press},  32'd1);
    check("midarm_fresh_level", {31'd0, bif.o_level},  32'd1);
    check("midarm_fresh_toggle", {31'd0, bif.o_toggle}, 32'd1);

    // Random bounce segments with occasional resets, checked against the model every edge.
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        for (int c = 0; c < int'($urandom_range(1, 3)); c++) step();
        rst_n = 1'b1;
      end
      bif.i_btn = 1'($urandom_range(0, 1));
      for (int c = 0; c < int'($urandom_range(1, 14)); c++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
